// File: rtl/usb_keyboard_report_arb.sv
`default_nettype none
// ============================================================================
// Module   : usb_keyboard_report_arb
// Purpose  : Round-robin arbiter over N_REQ key sources; each granted key is
//            serialised as an 8-byte HID boot-keyboard press report followed
//            by an 8-byte all-zero release report on the EP81 IN byte stream.
//            Optional USB_KBD_REPORT_CNT_EN adds a completed-report counter.
// Revision : 1.0 - initial release
// ============================================================================
module usb_keyboard_report_arb #(
    parameter int          N_REQ      = 2,
    parameter logic [15:0] GAP_CYCLES = 16'd600
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 usb_conn,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_key,
    output logic [N_REQ-1:0]     req_ready,
    output logic [2:0]           grant_idx,
    output logic                 busy,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef USB_KBD_REPORT_CNT_EN
    ,
    output logic [15:0]          report_cnt
`endif
);

    localparam logic [2:0] c_LAST_IDX = 3'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_bcnt, w_bcnt_nxt;
    logic [15:0] r_key, w_key_nxt;
    logic [15:0] r_gap_cnt, w_gap_nxt;
    logic [2:0]  r_grant, w_grant_nxt;

    logic [7:0]  w_req8;
    logic [3:0]  w_idx;
    logic        w_found;
    logic [2:0]  w_winner;
    logic [15:0] w_key_sel;
    logic        w_grant_en;
    logic        w_fire;
    logic        w_last_byte;

    assign w_req8      = 8'(req_valid);
    assign w_fire      = out_valid & out_ready;
    assign w_last_byte = w_fire && (r_bcnt == 3'd7);

    // Rotating search starting just after the previous winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_grant;
        w_idx    = 4'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_grant} + 4'(k);
            if (w_idx >= 4'(N_REQ)) begin
                w_idx = w_idx - 4'(N_REQ);
            end
            if (!w_found && w_req8[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_key_sel = 16'h0000;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_key_sel = req_key[16*i +: 16];
            end
        end
    end

    // req_ready is a same-cycle pulse; it is masked while reset or disconnect
    // is asserted so no key is ever acknowledged without being captured.
    assign w_grant_en = (r_state == S_IDLE) && w_found && usb_conn && rstn;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_grant_en && (w_winner == 3'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_key_nxt   = r_key;
        w_gap_nxt   = r_gap_cnt;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_grant_en) begin
                    w_state_nxt = S_PRESS;
                    w_grant_nxt = w_winner;
                    w_key_nxt   = w_key_sel;
                    w_bcnt_nxt  = 3'd0;
                end
            end
            S_PRESS: begin
                if (w_fire) begin
                    w_bcnt_nxt = r_bcnt + 3'd1;
                    if (r_bcnt == 3'd7) begin
                        w_state_nxt = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (w_fire) begin
                    w_bcnt_nxt = r_bcnt + 3'd1;
                    if (r_bcnt == 3'd7) begin
                        w_gap_nxt   = GAP_CYCLES;
                        w_state_nxt = (GAP_CYCLES == 16'd0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt <= 16'd1) begin
                    w_gap_nxt   = 16'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Disconnect drops any report in flight without a release report.
        if (!usb_conn) begin
            w_state_nxt = S_IDLE;
            w_bcnt_nxt  = 3'd0;
            w_gap_nxt   = 16'd0;
            w_grant_nxt = c_LAST_IDX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_bcnt    <= 3'd0;
            r_key     <= 16'h0000;
            r_gap_cnt <= 16'd0;
            r_grant   <= c_LAST_IDX;
        end else begin
            r_state   <= w_state_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_key     <= w_key_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_grant   <= w_grant_nxt;
        end
    end

    always_comb begin
        out_data = 8'h00;
        if (r_state == S_PRESS) begin
            if (r_bcnt == 3'd0) begin
                out_data = r_key[15:8];
            end else if (r_bcnt == 3'd2) begin
                out_data = r_key[7:0];
            end
        end
    end

    assign out_valid = (r_state == S_PRESS) || (r_state == S_RELEASE);
    assign busy      = (r_state != S_IDLE);
    assign grant_idx = r_grant;

`ifdef USB_KBD_REPORT_CNT_EN
    logic [15:0] r_report_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || !usb_conn) begin
            r_report_cnt <= 16'd0;
        end else if ((r_state == S_RELEASE) && w_last_byte) begin
            r_report_cnt <= r_report_cnt + 16'd1;
        end
    end

    assign report_cnt = r_report_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_keyboard_report_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_keyboard_report_arb
// Purpose  : Directed + randomized bench with a report-level reference model
//            and byte scoreboard for usb_keyboard_report_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_keyboard_report_arb;

    localparam int          N   = 3;
    localparam logic [15:0] GAP = 16'd4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            usb_conn;
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_key;
    logic [N-1:0]    req_ready;
    logic [2:0]      grant_idx;
    logic            busy;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
`ifdef USB_KBD_REPORT_CNT_EN
    logic [15:0]     report_cnt;
`endif

    usb_keyboard_report_arb #(
        .N_REQ      (N),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .usb_conn   (usb_conn),
        .req_valid  (req_valid),
        .req_key    (req_key),
        .req_ready  (req_ready),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef USB_KBD_REPORT_CNT_EN
        ,
        .report_cnt (report_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL timeout %s at %0t", nm, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a report is 16 bytes queued at grant time; after the
    // last byte leaves, GAP idle cycles must pass before the next grant.
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int  m_gap      = 0;
    int  m_last     = N - 1;
    int  m_pairs    = 0;
    int  grants     = 0;
    int  bytes_seen = 0;
    bit  mon_en     = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            bit         e_valid, e_busy, g_ok;
            int         w;
            logic [N-1:0] e_rdy;
            logic [15:0]  k;
            e_valid = (exp_q.size() > 0);
            e_busy  = e_valid || (m_gap > 0);
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("grant_idx", 32'(grant_idx), 32'(m_last));
`ifdef USB_KBD_REPORT_CNT_EN
            chk("report_cnt", 32'(report_cnt), 32'(m_pairs[15:0]));
`endif
            if (e_valid) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
            end else if (!e_busy) begin
                chk("idle_data", 32'(out_data), 32'd0);
            end

            g_ok  = rstn && usb_conn && !e_busy && (|req_valid);
            e_rdy = '0;
            w     = m_last;
            if (g_ok) begin
                for (int s = 1; s <= N; s++) begin
                    int c;
                    c = (m_last + s) % N;
                    if (req_valid[c] && w == m_last && !(e_rdy != 0)) begin
                        w = c;
                        e_rdy[c] = 1'b1;
                    end
                end
            end
            chk("req_ready", 32'(req_ready), 32'(e_rdy));

            if (!rstn || !usb_conn) begin
                exp_q.delete();
                m_gap   = 0;
                m_last  = N - 1;
                m_pairs = 0;
            end else begin
                if (!e_valid && m_gap > 0) m_gap--;
                if (e_valid && out_ready) begin
                    void'(exp_q.pop_front());
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        m_gap = int'(GAP);
                        m_pairs++;
                    end
                end
                if (g_ok) begin
                    k = req_key[16*w +: 16];
                    exp_q.push_back(k[15:8]);
                    exp_q.push_back(8'h00);
                    exp_q.push_back(k[7:0]);
                    repeat (13) exp_q.push_back(8'h00);
                    m_last = w;
                    grants++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 ns after the rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input int idx, input int maxc);
        int c;
        bit got;
        c = 0;
        got = 1'b0;
        while (!got && c < maxc) begin
            #2;
            got = req_ready[idx];
            step(1);
            c++;
        end
        if (!got) timeout("wait_grant");
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < maxc) begin
            step(1);
            c++;
        end
        if (c >= maxc) timeout("wait_idle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, g0, c;
        rstn      = 1'b0;
        usb_conn  = 1'b1;
        req_valid = '1;
        req_key   = '0;
        out_ready = 1'b1;
        step(1);
        mon_en = 1'b1;
        step(3);
        req_valid = '0;
        rstn      = 1'b1;
        step(2);

        // single key on requester 0
        req_key[15:0] = 16'h0204;
        req_valid     = 3'b001;
        wait_grant(0, 20);
        req_valid = '0;
        wait_idle(100);
        step(2);

        // round robin with all requesters held
        req_key   = {16'h0006, 16'h0005, 16'h0004};
        req_valid = 3'b111;
        g0 = grants;
        step(140);
        chk("rr_grant_count", 32'((grants - g0) >= 6), 32'd1);
        req_valid = '0;
        wait_idle(100);
        step(2);

        // backpressure 1,0,0,...
        req_key[15:0] = 16'h001E;
        req_valid     = 3'b001;
        wait_grant(0, 40);
        req_valid = '0;
        b0 = bytes_seen;
        for (int i = 0; i < 60; i++) begin
            out_ready = (i % 3 == 0);
            step(1);
        end
        out_ready = 1'b1;
        wait_idle(100);
        chk("bp_bytes", 32'(bytes_seen - b0), 32'd16);
        step(2);

        // disconnect mid-report, then a full report after reconnect
        req_key[31:16] = 16'h1111;
        req_valid      = 3'b010;
        wait_grant(1, 40);
        req_valid = '0;
        b0 = bytes_seen;
        c  = 0;
        while (bytes_seen < b0 + 5 && c < 50) begin
            step(1);
            c++;
        end
        if (c >= 50) timeout("disc_bytes");
        usb_conn  = 1'b0;
        out_ready = 1'b0;
        step(2);
        usb_conn  = 1'b1;
        out_ready = 1'b1;
        step(1);
        req_key[47:32] = 16'h2A2C;
        req_valid      = 3'b100;
        b0 = bytes_seen;
        wait_grant(2, 40);
        req_valid = '0;
        wait_idle(100);
        chk("reconn_bytes", 32'(bytes_seen - b0), 32'd16);
        step(2);

        // synchronous reset mid-PRESS with requests held
        req_key[15:0] = 16'h0517;
        req_valid     = 3'b001;
        wait_grant(0, 40);
        req_valid = 3'b111;
        step(2);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        step(3);
        req_valid = '0;
        wait_idle(200);
        step(2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            req_valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_key = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            usb_conn  = ($urandom_range(0, 199) != 0);
            rstn      = ($urandom_range(0, 299) != 0);
            step(1);
        end

        req_valid = '0;
        usb_conn  = 1'b1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        wait_idle(300);
        step(3);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_keyboard_report_arb.md
Name: usb_keyboard_report_arb

Overview:
- Arbitrates keystroke requests from N_REQ independent sources and serialises each accepted key into a HID boot-keyboard report pair: an 8-byte press report followed by an 8-byte all-zero release report.
- The byte stream drives the EP81 IN byte interface of the USB full-speed core (data/valid/ready).
- Sits between application key sources (UART bridge, button scanner, etc.) and the keyboard top level, replacing its single-source key_request path.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- GAP_CYCLES, 16'd600, idle clk cycles enforced after a release report before the next grant (0 = none).

Ports:
- clk  input  1  system clock, 60 MHz.
- rstn  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- usb_conn  input  1  1 = USB enumerated/connected; 0 = flush.
- req_valid  input  N_REQ  per-requester key request level.
- req_key  input  16*N_REQ  per-requester key; slice i = [16*i+15:16*i]; [15:8] modifier, [7:0] usage code.
- req_ready  output  N_REQ  one-cycle pulse on the granted requester when its key is captured.
- grant_idx  output  3  index of the last granted requester.
- busy  output  1  1 while not in IDLE.
- out_data  output  8  report byte to the EP81 data input.
- out_valid  output  1  to the EP81 valid input.
- out_ready  input  1  from the EP81 ready output; a byte is consumed on any cycle with out_valid=1 and out_ready=1.

Behaviour:
- Reset (rstn=0 at a clk edge) or usb_conn=0:
  - state=IDLE; req_ready=0; out_valid=0; out_data=0; busy=0; gap counter=0.
  - grant_idx=N_REQ-1, so requester 0 has first priority.
  - usb_conn=0 also aborts any report in flight mid-stream, with no release report sent.
- States: IDLE, PRESS, RELEASE, GAP.
- IDLE:
  - If usb_conn=1 and any req_valid=1, perform a round-robin grant.
  - Search order: grant_idx+1, grant_idx+2, ... wrapping modulo N_REQ; the first set bit wins.
  - Same cycle: update grant_idx, pulse req_ready[winner], latch req_key slice into key_reg, clear byte counter bcnt to 0, go to PRESS.
  - Next cycle: out_valid=1.
  - Latency: request seen to first byte valid = 1 cycle.
- PRESS:
  - out_data by bcnt: 0 → key_reg[15:8]; 1 → 8'h00; 2 → key_reg[7:0]; 3..7 → 8'h00.
  - On each consumed byte, bcnt increments.
  - When byte 7 is consumed, bcnt=0, go to RELEASE, and out_valid stays 1 (no bubble).
- RELEASE:
  - out_data=8'h00 for 8 bytes.
  - When byte 7 is consumed: out_valid=0 next cycle; load gap counter with GAP_CYCLES; go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP:
  - Counter decrements each cycle; go to IDLE when it reaches 1.
  - Requests are held off; req_ready stays 0.
- Byte rules:
  - out_data is stable while out_valid=1 and out_ready=0.
  - Exactly 16 bytes per grant.
- Request rules:
  - A requester that drops req_valid before its grant loses nothing; no request is queued internally.
  - A requester that holds req_valid after req_ready is granted again only after the GAP and its next round-robin turn.
  - Simultaneous requests are resolved by round-robin only; requester 0 has no fixed priority.
- N_REQ=1: grant_idx is constant 0.
- Arithmetic widths: bcnt 3 bits; gap counter 16 bits.

Optional Feature:
- Macro: USB_KBD_REPORT_CNT_EN.
- Defined:
  - Adds output report_cnt [15:0]: count of completed press+release pairs.
  - Increments when the last RELEASE byte is consumed; wraps 16'hFFFF → 0.
  - Cleared by reset and by usb_conn=0.
- Undefined: port absent; no counter logic.

Test Plan:
- Single key: req_valid[0]=1, req_key[15:0]=16'h0204, out_ready always 1 → stream 02 00 04 00 00 00 00 00 then eight 00; req_ready[0] pulses once; out_valid high exactly 16 cycles.
- Round robin: req_valid=2'b11 held, GAP_CYCLES=4 → grants alternate 0,1,0,1; grant_idx sequence 0,1,0,1; exactly 4 idle cycles between release end and the next req_ready.
- Backpressure: out_ready toggling 1,0,0,1,... with key 16'h001E → out_data held while out_ready=0; byte order is unchanged; 16 bytes total.
- Disconnect mid-report: usb_conn→0 after 5 bytes consumed → next cycle out_valid=0, state IDLE; after usb_conn→1, a new request yields a full 16-byte pair.
- Sync reset: rstn=0 for 1 cycle mid-PRESS → all outputs 0 at the next edge, grant_idx=N_REQ-1; with rstn low, no req_ready pulses occur even with req_valid=1.
- With USB_KBD_REPORT_CNT_EN: three keys sent → report_cnt=3; preload to 16'hFFFF via 65535 reports (or a forced counter value), one more report → 0.
